// File: rtl/div_seq_if.sv
// Request/response bundle between EX control and the sequential divider.
// DIV_FLUSH_EN adds a flush input driven by the requester.
interface div_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic            is_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_by_zero;
`ifdef DIV_FLUSH_EN
  logic            flush;

  modport master (
    output start, is_signed, dividend, divisor, flush,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, is_signed, dividend, divisor, flush,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider, signed/unsigned, fixed XLEN+1 cycle latency.
// Optional DIV_FLUSH_EN: flush input aborts any in-flight op without touching results.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  div_seq_if.slave bus
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem;
  logic [XLEN:0]   dvs;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvd_raw;
  logic            sign_q, sign_r, dz, ovf;
  logic [XLEN-1:0] q_out, r_out;
  logic            dz_out;

  logic            flush_i;
  logic            ready, accept;

`ifdef DIV_FLUSH_EN
  assign flush_i = bus.flush;
`else
  assign flush_i = 1'b0;
`endif

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = ready && bus.start && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = CALC;
        CALC:    if (cnt == '0) state_nx = ADJ;
        ADJ:     state_nx = DONE;
        DONE:    state_nx = accept ? CALC : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Magnitudes are formed at XLEN+1 bits so |most-negative| is representable.
  logic            dvd_neg, dvs_neg;
  logic [XLEN:0]   dvd_ext, dvs_ext, dvd_mag, dvs_mag;

  always_comb begin
    dvd_neg = bus.is_signed & bus.dividend[XLEN-1];
    dvs_neg = bus.is_signed & bus.divisor[XLEN-1];
    dvd_ext = {dvd_neg, bus.dividend};
    dvs_ext = {dvs_neg, bus.divisor};
    dvd_mag = dvd_neg ? ((XLEN+1)'(0) - dvd_ext) : dvd_ext;
    dvs_mag = dvs_neg ? ((XLEN+1)'(0) - dvs_ext) : dvs_ext;
  end

  logic [XLEN:0]   shifted, diff;
  logic            fits;

  always_comb begin
    shifted = {rem[XLEN-1:0], quo[XLEN-1]};
    fits    = (shifted >= dvs);
    diff    = shifted - dvs;
  end

  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    q_fix = sign_q ? (XLEN'(0) - quo) : quo;
    r_fix = sign_r ? (XLEN'(0) - rem[XLEN-1:0]) : rem[XLEN-1:0];
    // Special cases override the iterative result; latency is unchanged.
    if (dz) begin
      q_fix = '1;
      r_fix = dvd_raw;
    end else if (ovf) begin
      q_fix = MOST_NEG;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rem     <= '0;
      dvs     <= '0;
      quo     <= '0;
      dvd_raw <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      dz_out  <= 1'b0;
    end else begin
      if (accept) begin
        dvs     <= dvs_mag;
        quo     <= dvd_mag[XLEN-1:0];
        rem     <= '0;
        cnt     <= CW'(XLEN-1);
        dvd_raw <= bus.dividend;
        sign_q  <= dvd_neg ^ dvs_neg;
        sign_r  <= dvd_neg;
        dz      <= (bus.divisor == '0);
        ovf     <= bus.is_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);
      end else if (state == CALC && !flush_i) begin
        rem <= fits ? diff : shifted;
        quo <= {quo[XLEN-2:0], fits};
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
      if (state == ADJ && !flush_i) begin
        q_out  <= q_fix;
        r_out  <= r_fix;
        dz_out <= dz;
      end
    end
  end

  assign bus.busy        = (state == CALC) || (state == ADJ);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dz_out;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (XLEN=32); flush steps run when DIV_FLUSH_EN is defined.
module tb_div_seq;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  div_seq_if #(.XLEN(32)) bus ();

  div_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sg, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.is_signed = sg;
    bus.dividend  = a;
    bus.divisor   = b;
  endtask

  // Called #1 after the accepting edge; counts edges until done, and busy samples before done.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.done !== 1'b1 && bus.busy === 1'b1) nb++;
    end
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int n, nb;
    drive(sg, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n, nb);
    chk({tag, "_lat"},  64'(n),  64'd33);
    chk({tag, "_busy"}, 64'(nb), 64'd33);
    chk({tag, "_q"},    64'(bus.quotient),    64'(eq));
    chk({tag, "_r"},    64'(bus.remainder),   64'(er));
    chk({tag, "_dz"},   64'(bus.div_by_zero), 64'(edz));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(bus.done),     64'd0);
    chk({tag, "_hold"},  64'(bus.quotient), 64'(eq));
  endtask

  initial begin
    int n, nb, saw;
    rst = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
`ifdef DIV_FLUSH_EN
    bus.flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_q",    64'(bus.quotient), 64'd0);
    chk("rst_r",    64'(bus.remainder), 64'd0);
    chk("rst_dz",   64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("u100_7",   1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0);
    run_op("sm100_7",  1'b1, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
    run_op("s100_m7",  1'b1, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0);
    run_op("sm100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0);
    run_op("s7_100",   1'b1, 32'd7,        32'd100,        32'd0,          32'd7,          1'b0);
    run_op("umax_1",   1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0);
    run_op("dz_u",     1'b0, 32'h12345678, 32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1);
    run_op("dz_s",     1'b1, 32'h12345678, 32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1);
    run_op("dz_sneg",  1'b1, 32'h80000001, 32'd0,          32'hFFFFFFFF,   32'h80000001,   1'b1);
    run_op("ovf_s",    1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
    run_op("ovf_u",    1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0);

    // Back-to-back with a stray start pulse while busy.
    drive(1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    drive(1'b0, 32'd5, 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dividend = 32'd999; bus.divisor = 32'd3;
    wait_done(n, nb);
    chk("b2b_a_lat", 64'(n + 6), 64'd33);
    chk("b2b_a_q",   64'(bus.quotient),  64'd14);
    chk("b2b_a_r",   64'(bus.remainder), 64'd2);
    drive(1'b0, 32'd1000, 32'd10);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_noidle", 64'(bus.busy), 64'd1);
    wait_done(n, nb);
    chk("b2b_b_lat",  64'(n),  64'd33);
    chk("b2b_b_busy", 64'(nb), 64'd33);
    chk("b2b_b_q",    64'(bus.quotient),  64'd100);
    chk("b2b_b_r",    64'(bus.remainder), 64'd0);
    @(posedge clk); #1;

    // Reset mid-CALC aborts the op.
    drive(1'b1, 32'hFFFFFF9C, 32'd7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_q",    64'(bus.quotient), 64'd0);
    chk("abort_r",    64'(bus.remainder), 64'd0);
    chk("abort_dz",   64'(bus.div_by_zero), 64'd0);
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw++;
    end
    chk("abort_quiet", 64'(saw), 64'd0);

`ifdef DIV_FLUSH_EN
    run_op("pre_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    drive(1'b0, 32'd50, 32'd5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    drive(1'b0, 32'd77, 32'd7);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_q",    64'(bus.quotient),  64'd14);
    chk("flush_r",    64'(bus.remainder), 64'd2);
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw++;
    end
    chk("flush_quiet", 64'(saw), 64'd0);
    run_op("post_flush", 1'b0, 32'd77, 32'd7, 32'd11, 32'd0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
